branch_resolve_unit: RTL and testbench

- Parametrised, registered successor to the pipeline's branch comparator. Resolves conditional branches in EX with 8 compare modes and WIDTH-bit operands, computes the branch target, and registers the outcome to EX/MEM.
- Holds a bimodal predictor: 2^IDX_BITS 2-bit saturating counters. The fetch stage reads it; resolved branches train it. A mispredict flag drives the pipeline flush.

---
 rtl/branch_resolve_unit.sv | 186 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves conditional branches in the EX stage and registers the outcome
// into EX/MEM. It also owns the bimodal branch predictor: a table of
// 2^IDX_BITS two-bit saturating counters. The fetch stage reads the table
// through lookupPc, and resolved branches train it.
//
// Optional feature (compile-time macro BRU_BYPASS_EN):
//   Defined   - when a training write and the fetch lookup hit the same
//               entry in one cycle, predTaken forwards the post-update MSB.
//   Undefined - predTaken always reads the stored counter value.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   stall        hold every register and counter (predTaken still live)
//   flush        kill the instruction entering this cycle
//   validIn      EX-stage instruction valid
//   branchOp     compare mode (000 none ... 111 always taken)
//   opA, opB     compare operands
//   pcIn         PC of the branch being resolved
//   offset       two's-complement branch offset
//   predTakenIn  fetch-time prediction carried down the pipe
//   lookupPc     fetch-stage PC used to read the predictor
//   predTaken    combinational prediction for lookupPc
//   validOut     registered valid
//   jmpTrue      registered branch outcome (0 when validOut is 0)
//   result       registered opA - opB
//   redirectPc   registered jmpTrue ? pcIn + offset : pcIn + 1
//   mispredict   registered flush request for a wrong prediction
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int WIDTH    = 16,
   parameter int PC_WIDTH = 16,
   parameter int IDX_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic                validIn,
   input  logic [2:0]          branchOp,
   input  logic [WIDTH-1:0]    opA,
   input  logic [WIDTH-1:0]    opB,
   input  logic [PC_WIDTH-1:0] pcIn,
   input  logic [PC_WIDTH-1:0] offset,
   input  logic                predTakenIn,
   input  logic [PC_WIDTH-1:0] lookupPc,
   output logic                predTaken,
   output logic                validOut,
   output logic                jmpTrue,
   output logic [WIDTH-1:0]    result,
   output logic [PC_WIDTH-1:0] redirectPc,
   output logic                mispredict
);

   localparam int ENTRIES = 1 << IDX_BITS;

   localparam logic [2:0] OP_NONE = 3'b000;
   localparam logic [2:0] OP_SLT  = 3'b001;
   localparam logic [2:0] OP_SGT  = 3'b010;
   localparam logic [2:0] OP_EQ   = 3'b011;
   localparam logic [2:0] OP_NE   = 3'b100;
   localparam logic [2:0] OP_ULT  = 3'b101;
   localparam logic [2:0] OP_UGE  = 3'b110;
   localparam logic [2:0] OP_ALW  = 3'b111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } counterState_e;

   counterState_e counterTable [ENTRIES];

   logic                taken;
   logic                acceptBranch;
   logic                trainEn;
   logic [IDX_BITS-1:0] trainIdx;
   logic [IDX_BITS-1:0] lookupIdx;
   counterState_e       currentCount;
   counterState_e       nextCount;
   logic [PC_WIDTH-1:0] targetPc;
   logic [PC_WIDTH-1:0] seqPc;
   logic                unusedLookupBits;

   // The predictor is indexed by the low PC bits only; the upper fetch PC
   // bits are folded here so they are visibly consumed.
   assign unusedLookupBits = ^lookupPc[PC_WIDTH-1:IDX_BITS];

   assign trainIdx  = pcIn[IDX_BITS-1:0];
   assign lookupIdx = lookupPc[IDX_BITS-1:0];
   assign targetPc  = pcIn + offset;
   assign seqPc     = pcIn + PC_WIDTH'(1);

   // An instruction is accepted into EX/MEM only when the pipe moves and it
   // has not been killed; training additionally needs a real branch.
   assign acceptBranch = validIn && !stall && !flush;
   assign trainEn      = acceptBranch && (branchOp != OP_NONE);

   // Branch condition evaluation. Signed modes reinterpret the operands as
   // two's complement; unsigned modes compare raw bit patterns.
   always_comb begin
      taken = 1'b0;
      case (branchOp)
         OP_NONE: taken = 1'b0;
         OP_SLT:  taken = $signed(opA) < $signed(opB);
         OP_SGT:  taken = $signed(opA) > $signed(opB);
         OP_EQ:   taken = (opA == opB);
         OP_NE:   taken = (opA != opB);
         OP_ULT:  taken = (opA < opB);
         OP_UGE:  taken = (opA >= opB);
         OP_ALW:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // Next state of the counter being trained. It walks one step toward
   // strongly-taken or strongly-not-taken and sticks at either end.
   always_comb begin
      currentCount = counterTable[trainIdx];
      nextCount    = currentCount;
      if (taken) begin
         case (currentCount)
            SNT:     nextCount = WNT;
            WNT:     nextCount = WT;
            WT:      nextCount = ST;
            ST:      nextCount = ST;
            default: nextCount = WNT;
         endcase
      end else begin
         case (currentCount)
            ST:      nextCount = WT;
            WT:      nextCount = WNT;
            WNT:     nextCount = SNT;
            SNT:     nextCount = SNT;
            default: nextCount = WNT;
         endcase
      end
   end

   // Fetch-side prediction. Without the bypass the stored counter is
   // returned even while that entry is being written this cycle.
   always_comb begin
      predTaken = counterTable[lookupIdx][1];
`ifdef BRU_BYPASS_EN
      if (trainEn && (trainIdx == lookupIdx)) begin
         predTaken = nextCount[1];
      end
`endif
   end

   // Predictor table state. Every entry wakes up weakly-not-taken, and
   // only the entry of an accepted branch is written.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            counterTable[i] <= WNT;
         end
      end else if (trainEn) begin
         counterTable[trainIdx] <= nextCount;
      end
   end

   // EX/MEM outcome register. Killed or invalid slots clear the qualified
   // flags; result and redirectPc still load since nobody looks at them
   // without validOut. A stall freezes the whole register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         validOut   <= 1'b0;
         jmpTrue    <= 1'b0;
         mispredict <= 1'b0;
         result     <= '0;
         redirectPc <= '0;
      end else if (!stall) begin
         validOut   <= acceptBranch;
         jmpTrue    <= acceptBranch && taken;
         mispredict <= trainEn && (predTakenIn != taken);
         result     <= opA - opB;
         redirectPc <= taken ? targetPc : seqPc;
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit with the default parameters
// (WIDTH=16, PC_WIDTH=16, IDX_BITS=4). Expected values are hand-computed
// and written next to each step. Define BRU_BYPASS_EN for both the bench
// and the design to check the forwarding variant.
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        validIn;
   logic [2:0]  branchOp;
   logic [15:0] opA;
   logic [15:0] opB;
   logic [15:0] pcIn;
   logic [15:0] offset;
   logic        predTakenIn;
   logic [15:0] lookupPc;
   logic        predTaken;
   logic        validOut;
   logic        jmpTrue;
   logic [15:0] result;
   logic [15:0] redirectPc;
   logic        mispredict;

   int assertCount = 0;
   int failCount   = 0;

   branch_resolve_unit #(
      .WIDTH(16),
      .PC_WIDTH(16),
      .IDX_BITS(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .flush(flush),
      .validIn(validIn),
      .branchOp(branchOp),
      .opA(opA),
      .opB(opB),
      .pcIn(pcIn),
      .offset(offset),
      .predTakenIn(predTakenIn),
      .lookupPc(lookupPc),
      .predTaken(predTaken),
      .validOut(validOut),
      .jmpTrue(jmpTrue),
      .result(result),
      .redirectPc(redirectPc),
      .mispredict(mispredict)
   );

   // 10 ns clock, rising edge active.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts the check and reports any miss.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one EX-stage instruction onto the inputs.
   task automatic applyStimulus(input logic v, input logic [2:0] op,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] pc, input logic [15:0] off,
                                input logic predIn);
      validIn     = v;
      branchOp    = op;
      opA         = a;
      opB         = b;
      pcIn        = pc;
      offset      = off;
      predTakenIn = predIn;
   endtask

   // Advance to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Check the full registered output set in one call.
   task automatic checkRegs(input string tag, input logic v, input logic j,
                            input logic [15:0] r, input logic [15:0] rp,
                            input logic m);
      checkOutput({tag, ".validOut"}, {31'b0, validOut}, {31'b0, v});
      checkOutput({tag, ".jmpTrue"}, {31'b0, jmpTrue}, {31'b0, j});
      checkOutput({tag, ".result"}, {16'b0, result}, {16'b0, r});
      checkOutput({tag, ".redirectPc"}, {16'b0, redirectPc}, {16'b0, rp});
      checkOutput({tag, ".mispredict"}, {31'b0, mispredict}, {31'b0, m});
   endtask

   // Look up one predictor entry and compare its prediction.
   task automatic checkPred(input string tag, input logic [15:0] pc,
                            input logic expected);
      lookupPc = pc;
      #1;
      checkOutput(tag, {31'b0, predTaken}, {31'b0, expected});
   endtask

   logic bypassExpect;

   initial begin
      rst      = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      lookupPc = 16'h0000;
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      #2;

      // Reset: every counter weakly-not-taken, all outputs cleared.
      checkRegs("reset", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 16; i++) begin
         checkPred("resetPred", 16'(i), 1'b0);
      end
      @(negedge clk);
      rst = 1'b1;
      nextCycle();

      // Signed less-than: -10 < 5 taken, 0xFFF6-5 = 0xFFF1, pc 1 + 4 = 5.
      applyStimulus(1'b1, 3'b001, 16'hFFF6, 16'h0005, 16'h0001, 16'h0004, 1'b0);
      nextCycle();
      checkRegs("slt", 1'b1, 1'b1, 16'hFFF1, 16'h0005, 1'b1);
      checkPred("sltTrain", 16'h0001, 1'b1);

      // Unsigned less-than: 0xFFF6 < 5 false, redirect to pc+1 = 3.
      applyStimulus(1'b1, 3'b101, 16'hFFF6, 16'h0005, 16'h0002, 16'h0004, 1'b0);
      nextCycle();
      checkRegs("ult", 1'b1, 1'b0, 16'hFFF1, 16'h0003, 1'b0);
      checkPred("ultTrain", 16'h0002, 1'b0);

      // Equal, backward branch: 0x20 + 0xFFFC = 0x1C, predicted not taken.
      applyStimulus(1'b1, 3'b011, 16'd10, 16'd10, 16'h0020, 16'hFFFC, 1'b0);
      nextCycle();
      checkRegs("eq", 1'b1, 1'b1, 16'h0000, 16'h001C, 1'b1);
      checkPred("eqTrainIdx0", 16'h0010, 1'b1);

      // Signed greater-than: 5 > -10 taken, 5 - 0xFFF6 = 0x000F.
      applyStimulus(1'b1, 3'b010, 16'h0005, 16'hFFF6, 16'h0008, 16'h0002, 1'b1);
      nextCycle();
      checkRegs("sgt", 1'b1, 1'b1, 16'h000F, 16'h000A, 1'b0);

      // Unsigned greater-or-equal on equal operands is taken.
      applyStimulus(1'b1, 3'b110, 16'h8000, 16'h8000, 16'h0009, 16'h0100, 1'b0);
      nextCycle();
      checkRegs("uge", 1'b1, 1'b1, 16'h0000, 16'h0109, 1'b1);

      // Four always-taken branches on pc 3: 01 -> 10 -> 11 -> 11 -> 11.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 3'b111, 16'h0000, 16'h0000, 16'h0003, 16'h0010, 1'b1);
         nextCycle();
      end
      checkRegs("always", 1'b1, 1'b1, 16'h0000, 16'h0013, 1'b0);
      checkPred("satTaken", 16'h0003, 1'b1);

      // First not-taken (7 != 7 false) drops 11 -> 10: prediction stays 1.
      applyStimulus(1'b1, 3'b100, 16'h0007, 16'h0007, 16'h0003, 16'h0010, 1'b1);
      nextCycle();
      checkRegs("ne", 1'b1, 1'b0, 16'h0000, 16'h0004, 1'b1);
      checkPred("satNt1", 16'h0003, 1'b1);

      // Second not-taken drops 10 -> 01: prediction flips to 0.
      applyStimulus(1'b1, 3'b100, 16'h0007, 16'h0007, 16'h0003, 16'h0010, 1'b1);
      nextCycle();
      checkPred("satNt2", 16'h0003, 1'b0);

      // Op none at pc 0xFFFF: pc+1 wraps to 0, no training of entry 15.
      applyStimulus(1'b1, 3'b000, 16'h0003, 16'h0001, 16'hFFFF, 16'h0010, 1'b1);
      nextCycle();
      checkRegs("noneWrap", 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
      checkPred("noneNoTrain", 16'h000F, 1'b0);

      // Stall three cycles with a taken branch at pc 6 waiting.
      applyStimulus(1'b1, 3'b111, 16'h0009, 16'h0001, 16'h0006, 16'h0002, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         checkRegs("stall", 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
         checkPred("stallNoTrain", 16'h0006, 1'b0);
      end

      // Flush without stall kills the branch and blocks training.
      stall = 1'b0;
      flush = 1'b1;
      nextCycle();
      checkOutput("flush.validOut", {31'b0, validOut}, 32'd0);
      checkOutput("flush.jmpTrue", {31'b0, jmpTrue}, 32'd0);
      checkOutput("flush.mispredict", {31'b0, mispredict}, 32'd0);
      checkPred("flushNoTrain", 16'h0006, 1'b0);
      flush = 1'b0;

      // validIn low behaves like a flush.
      applyStimulus(1'b0, 3'b111, 16'h0009, 16'h0001, 16'h0006, 16'h0002, 1'b0);
      nextCycle();
      checkOutput("invalid.validOut", {31'b0, validOut}, 32'd0);
      checkOutput("invalid.jmpTrue", {31'b0, jmpTrue}, 32'd0);
      checkPred("invalidNoTrain", 16'h0006, 1'b0);

      // Same-cycle lookup and training of entry 5 (01 -> 10).
`ifdef BRU_BYPASS_EN
      bypassExpect = 1'b1;
`else
      bypassExpect = 1'b0;
`endif
      applyStimulus(1'b1, 3'b111, 16'h0000, 16'h0000, 16'h0005, 16'h0001, 1'b0);
      checkPred("sameCycleLookup", 16'h0005, bypassExpect);
      nextCycle();
      checkRegs("idx5", 1'b1, 1'b1, 16'h0000, 16'h0006, 1'b1);
      checkPred("idx5After", 16'h0005, 1'b1);

      // Asynchronous reset mid-cycle while stalled: counters back to 01 now.
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      stall = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      checkRegs("midReset", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      checkPred("midResetIdx5", 16'h0005, 1'b0);
      checkPred("midResetIdx0", 16'h0000, 1'b0);
      checkPred("midResetIdx8", 16'h0008, 1'b0);
      checkPred("midResetIdx1", 16'h0001, 1'b0);

      // Release and train entry 0 once more from WNT.
      @(negedge clk);
      rst   = 1'b1;
      stall = 1'b0;
      nextCycle();
      applyStimulus(1'b1, 3'b111, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 1'b1);
      nextCycle();
      checkRegs("postReset", 1'b1, 1'b1, 16'h0000, 16'h0004, 1'b0);
      checkPred("postResetIdx0", 16'h0000, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
